// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector read path.
//   SD_SECTOR_BITS      - width of the controller sector bus
//   SD_WORD_BITS        - width of one streamed word
//   SD_WORDS_PER_SECTOR - words per sector (128)
//   sd_state_t          - streamer FSM encoding (ST_IDLE/ST_REQ/ST_STREAM/ST_DONE)
package sd_pkg;
    localparam int SD_SECTOR_BITS      = 4096;
    localparam int SD_WORD_BITS        = 32;
    localparam int SD_WORDS_PER_SECTOR = SD_SECTOR_BITS / SD_WORD_BITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } sd_state_t;
endpackage

// File: rtl/sd_sector_unpacker.sv
// Holds one captured sector and presents it one word at a time.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   i_load      - capture i_data into the sector register, index back to 0
//   i_data      - full sector from the controller
//   i_advance   - step to the next word (ignored on the last word)
//   o_word      - word at the current index (bits [W*k+W-1:W*k])
//   o_index     - current word index
//   o_last      - current index is the final word of the sector
module sd_sector_unpacker
    import sd_pkg::*;
#(
    parameter int  SECTOR_BITS = SD_SECTOR_BITS,
    parameter int  WORD_BITS   = SD_WORD_BITS,
    localparam int WORDS       = SECTOR_BITS / WORD_BITS,
    localparam int IDX_W       = $clog2(WORDS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_load,
    input  logic [SECTOR_BITS-1:0] i_data,
    input  logic                   i_advance,
    output logic [WORD_BITS-1:0]   o_word,
    output logic [IDX_W-1:0]       o_index,
    output logic                   o_last
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    // Word k occupies bits [WORD_BITS*k +: WORD_BITS], so a packed 2-D view indexes it directly.
    logic [WORDS-1:0][WORD_BITS-1:0] r_sector;
    logic [IDX_W-1:0]                r_index;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sector <= '0;
            r_index  <= '0;
        end else if (i_load) begin
            r_sector <= i_data;
            r_index  <= '0;
        end else if (i_advance && !o_last) begin
            // Index parks on the last word; the FSM leaves STREAM instead of wrapping.
            r_index <= r_index + 1'b1;
        end
    end

    assign o_word  = r_sector[r_index];
    assign o_index = r_index;
    assign o_last  = (r_index == LAST_IDX);
endmodule

// File: rtl/sd_sector_streamer.sv
// Requests one sector from the SD controller, captures it, then streams it out
// as WORD_BITS-wide words over a valid/ready interface.
// Optional feature macro: SD_READ_TIMEOUT_EN - watchdog on the controller
// response; after TIMEOUT_CYCLES in REQ without sd_ctrl_done, pulse rd_err and
// return to IDLE. Without it REQ waits forever and rd_err stays 0.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   rd_req, rd_sector     - start a read (accepted only in IDLE) and its address
//   busy                  - any state other than IDLE
//   sd_ctrl_addr_read/re  - controller read address and read enable (REQ only)
//   sd_ctrl_done/data_read- controller completion pulse and sector data
//   word_valid/ready      - word stream handshake
//   word_data/word_index  - current word and its index
//   sector_done           - one-cycle pulse after the last word handshake
//   rd_err                - one-cycle pulse on watchdog expiry
module sd_sector_streamer
    import sd_pkg::*;
#(
    parameter int  SECTOR_BITS    = SD_SECTOR_BITS,
    parameter int  WORD_BITS      = SD_WORD_BITS,
    parameter int  TIMEOUT_CYCLES = 2**20,
    localparam int IDX_W          = $clog2(SECTOR_BITS / WORD_BITS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_req,
    input  logic [31:0]            rd_sector,
    output logic                   busy,
    output logic [31:0]            sd_ctrl_addr_read,
    output logic                   sd_ctrl_re,
    input  logic                   sd_ctrl_done,
    input  logic [SECTOR_BITS-1:0] sd_ctrl_data_read,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [WORD_BITS-1:0]   word_data,
    output logic [IDX_W-1:0]       word_index,
    output logic                   sector_done,
    output logic                   rd_err
);
    sd_state_t   r_state;
    logic        r_busy, r_re, r_valid, r_sdone, r_err;
    logic [31:0] r_addr;
    logic        w_load, w_adv, w_last, w_timeout;

    // Controller completion counts only while a request is outstanding.
    assign w_load = (r_state == ST_REQ) && sd_ctrl_done;
    assign w_adv  = (r_state == ST_STREAM) && r_valid && word_ready;

`ifdef SD_READ_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_cnt;

    // r_cnt = number of REQ cycles already spent; fires on the TIMEOUT_CYCLES-th.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (r_state == ST_IDLE)
            r_cnt <= '0;
        else if (r_state == ST_REQ)
            r_cnt <= r_cnt + 1'b1;
    end

    // A completion in the expiry cycle still wins.
    assign w_timeout = (r_state == ST_REQ) && !sd_ctrl_done && (r_cnt == CNT_LAST);
`else
    logic w_unused_timeout;
    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_re    <= 1'b0;
            r_valid <= 1'b0;
            r_sdone <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_sdone <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: if (rd_req) begin
                    r_addr  <= rd_sector;
                    r_re    <= 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= ST_REQ;
                end
                ST_REQ: if (sd_ctrl_done) begin
                    r_re    <= 1'b0;
                    r_valid <= 1'b1;
                    r_state <= ST_STREAM;
                end else if (w_timeout) begin
                    r_re    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                ST_STREAM: if (w_adv && w_last) begin
                    r_valid <= 1'b0;
                    r_sdone <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sd_sector_unpacker #(
        .SECTOR_BITS (SECTOR_BITS),
        .WORD_BITS   (WORD_BITS)
    ) u_unpacker (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_data    (sd_ctrl_data_read),
        .i_advance (w_adv),
        .o_word    (word_data),
        .o_index   (word_index),
        .o_last    (w_last)
    );

    assign busy              = r_busy;
    assign sd_ctrl_addr_read = r_addr;
    assign sd_ctrl_re        = r_re;
    assign word_valid        = r_valid;
    assign sector_done       = r_sdone;
    assign rd_err            = r_err;
endmodule
